ram_port_arbiter: RTL and testbench

Sequencer and arbiter for the single port of the 64 KB system SRAM. It is shared by three requesters:
- the SPI flash loader during boot;
- the 6502 bus, qualified by phi2, during normal running;
- the diagnostics module while the CPU is halted.

It replaces the ad-hoc mux chain in front of the SRAM with registered grants, a phi2-synchronised CPU slot and a clean halt handshake.

---
 rtl/ram_port_arbiter.sv | 255 +++++++++++++++++++++++++
 tb/tb_ram_port_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
//   Sequencer/arbiter for the single port of the 64 KB system SRAM.
//   Owners: flash loader (BOOT), 6502 bus slot synchronised to phi2 (RUN),
//   diagnostics (HALTED). One access is outstanding at a time; every ram_*
//   output is a register. Request sampled at E0, ram_cs during E0..E1,
//   rdata captured and ack pulsed at E2.
//
//   Ports:
//     clk_i, rst_ni                    clock, async active-low reset
//     boot_done_i                      flash image loaded (sticky once seen)
//     flash_req/addr/wdata/we_i        flash loader access, flash_ack_o pulse
//     phi2_i                           6502 clock, asynchronous to clk_i
//     cpu_cs/we/addr/wdata_i           decoded CPU bus, cpu_rdata_o held
//     halt_req_i, halt_o               diagnostics halt handshake
//     diag_req/addr/wdata/we_i         diag access, diag_ack_o, diag_rdata_o
//     ram_addr/wdata/cs/we_o, ram_rdata_i   SRAM port (rdata one clk after cs)
//
//   Build option: RAM_ARB_DIAG_WRITE_EN -- when defined, diagnostics writes
//   reach the RAM; otherwise diag writes are acked but ram_we stays low.
module ram_port_arbiter #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 8,
    parameter int CPU_GUARD = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              boot_done_i,
    input  logic              flash_req_i,
    input  logic [ADDR_W-1:0] flash_addr_i,
    input  logic [DATA_W-1:0] flash_wdata_i,
    input  logic              flash_we_i,
    output logic              flash_ack_o,
    input  logic              phi2_i,
    input  logic              cpu_cs_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    output logic [DATA_W-1:0] cpu_rdata_o,
    input  logic              halt_req_i,
    output logic              halt_o,
    input  logic              diag_req_i,
    input  logic [ADDR_W-1:0] diag_addr_i,
    input  logic [DATA_W-1:0] diag_wdata_i,
    input  logic              diag_we_i,
    output logic              diag_ack_o,
    output logic [DATA_W-1:0] diag_rdata_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_wdata_o,
    output logic              ram_cs_o,
    output logic              ram_we_o,
    input  logic [DATA_W-1:0] ram_rdata_i
);

    typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_HALT_PEND, ST_HALTED} state_e;
    typedef enum logic [1:0] {OWN_FLASH, OWN_CPU, OWN_DIAG} own_e;

    localparam logic [3:0] GUARD_L = 4'(CPU_GUARD);

    state_e            state_q, state_d;
    logic              halt_q, halt_d;
    logic              boot_seen_q, boot_seen_d;
    logic              phi2_s1_q, phi2_s2_q, phi2_s3_q;
    logic              grd_act_q, grd_act_d;
    logic [3:0]        grd_cnt_q, grd_cnt_d;
    // stage 1: access on the RAM pins
    logic              ram_cs_q, ram_we_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [DATA_W-1:0] ram_wdata_q;
    own_e              own1_q;
    logic              req_we1_q;
    // stage 2: RAM data valid, capture and ack on the next edge
    logic              s2_vld_q, s2_we_q;
    own_e              s2_own_q;
    logic              flash_ack_q, diag_ack_q;
    logic [DATA_W-1:0] cpu_rdata_q, diag_rdata_q;

    logic              iss, iss_we, iss_ram_we, cpu_slot;
    own_e              iss_own;
    logic [ADDR_W-1:0] iss_addr;
    logic [DATA_W-1:0] iss_wdata;

    // Held requests stay high through the ack cycle, so the ack stage also
    // blocks a new issue; otherwise the same request would be taken twice.
    wire inflight  = ram_cs_q | s2_vld_q;
    wire busy      = inflight | flash_ack_q | diag_ack_q;
    wire phi2_rise = phi2_s2_q & ~phi2_s3_q;
    wire cpu_phase = (state_q == ST_RUN) || (state_q == ST_HALT_PEND);

    always_comb begin
        state_d     = state_q;
        halt_d      = halt_q;
        boot_seen_d = boot_seen_q | boot_done_i;
        grd_act_d   = grd_act_q;
        grd_cnt_d   = grd_cnt_q;
        cpu_slot    = 1'b0;
        iss         = 1'b0;
        iss_own     = OWN_FLASH;
        iss_we      = 1'b0;
        iss_ram_we  = 1'b0;
        iss_addr    = '0;
        iss_wdata   = '0;

        // Guard counter: one slot per phi2-high phase; a phase that ends
        // before the guard expires is skipped.
        if (cpu_phase) begin
            if (phi2_rise) begin
                if (CPU_GUARD == 0) begin
                    cpu_slot = 1'b1;
                end else begin
                    grd_act_d = 1'b1;
                    grd_cnt_d = 4'd1;
                end
            end else if (grd_act_q) begin
                if (!phi2_s2_q) begin
                    grd_act_d = 1'b0;
                    grd_cnt_d = '0;
                end else if (grd_cnt_q == GUARD_L) begin
                    cpu_slot  = 1'b1;
                    grd_act_d = 1'b0;
                    grd_cnt_d = '0;
                end else begin
                    grd_cnt_d = grd_cnt_q + 4'd1;
                end
            end
        end else begin
            grd_act_d = 1'b0;
            grd_cnt_d = '0;
        end

        case (state_q)
            ST_BOOT: begin
                if (boot_seen_d && !inflight) begin
                    state_d = ST_RUN;
                end else if (flash_req_i && !busy) begin
                    iss        = 1'b1;
                    iss_own    = OWN_FLASH;
                    iss_we     = flash_we_i;
                    iss_ram_we = flash_we_i;
                    iss_addr   = flash_addr_i;
                    iss_wdata  = flash_wdata_i;
                end
            end
            ST_RUN: begin
                if (halt_req_i) state_d = ST_HALT_PEND;
            end
            ST_HALT_PEND: begin
                if (!halt_req_i) begin
                    state_d = ST_RUN;
                end else if (!phi2_s2_q && !inflight) begin
                    state_d = ST_HALTED;
                    halt_d  = 1'b1;
                end
            end
            ST_HALTED: begin
                if (!halt_req_i) begin
                    if (!inflight) begin
                        state_d = ST_RUN;
                        halt_d  = 1'b0;
                    end
                end else if (diag_req_i && !busy) begin
                    iss       = 1'b1;
                    iss_own   = OWN_DIAG;
                    iss_we    = diag_we_i;
                    iss_addr  = diag_addr_i;
                    iss_wdata = diag_wdata_i;
`ifdef RAM_ARB_DIAG_WRITE_EN
                    iss_ram_we = diag_we_i;
`else
                    iss_ram_we = 1'b0;
`endif
                end
            end
            default: state_d = ST_BOOT;
        endcase

        // cpu_slot only fires in RUN/HALT_PEND, so it never collides with
        // a flash or diag issue.
        if (cpu_slot && cpu_cs_i && !busy) begin
            iss        = 1'b1;
            iss_own    = OWN_CPU;
            iss_we     = cpu_we_i;
            iss_ram_we = cpu_we_i;
            iss_addr   = cpu_addr_i;
            iss_wdata  = cpu_wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_BOOT;
            halt_q       <= 1'b0;
            boot_seen_q  <= 1'b0;
            phi2_s1_q    <= 1'b0;
            phi2_s2_q    <= 1'b0;
            phi2_s3_q    <= 1'b0;
            grd_act_q    <= 1'b0;
            grd_cnt_q    <= '0;
            ram_cs_q     <= 1'b0;
            ram_we_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
            own1_q       <= OWN_FLASH;
            req_we1_q    <= 1'b0;
            s2_vld_q     <= 1'b0;
            s2_we_q      <= 1'b0;
            s2_own_q     <= OWN_FLASH;
            flash_ack_q  <= 1'b0;
            diag_ack_q   <= 1'b0;
            cpu_rdata_q  <= '0;
            diag_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            halt_q      <= halt_d;
            boot_seen_q <= boot_seen_d;
            phi2_s1_q   <= phi2_i;
            phi2_s2_q   <= phi2_s1_q;
            phi2_s3_q   <= phi2_s2_q;
            grd_act_q   <= grd_act_d;
            grd_cnt_q   <= grd_cnt_d;

            ram_cs_q <= iss;
            ram_we_q <= iss & iss_ram_we;
            if (iss) begin
                ram_addr_q  <= iss_addr;
                ram_wdata_q <= iss_wdata;
                own1_q      <= iss_own;
                req_we1_q   <= iss_we;
            end

            s2_vld_q <= ram_cs_q;
            s2_own_q <= own1_q;
            s2_we_q  <= req_we1_q;

            flash_ack_q <= s2_vld_q && (s2_own_q == OWN_FLASH);
            diag_ack_q  <= s2_vld_q && (s2_own_q == OWN_DIAG);
            // Write requests (including suppressed diag writes) never
            // disturb the held read data.
            if (s2_vld_q && !s2_we_q) begin
                if (s2_own_q == OWN_CPU)  cpu_rdata_q  <= ram_rdata_i;
                if (s2_own_q == OWN_DIAG) diag_rdata_q <= ram_rdata_i;
            end
        end
    end

    assign flash_ack_o  = flash_ack_q;
    assign diag_ack_o   = diag_ack_q;
    assign cpu_rdata_o  = cpu_rdata_q;
    assign diag_rdata_o = diag_rdata_q;
    assign halt_o       = halt_q;
    assign ram_cs_o     = ram_cs_q;
    assign ram_we_o     = ram_we_q;
    assign ram_addr_o   = ram_addr_q;
    assign ram_wdata_o  = ram_wdata_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: main instance with CPU_GUARD=2 on a
// behavioural SRAM, plus a CPU_GUARD=4 instance (constant RAM data) for the
// short-phi2 case. Inputs driven and outputs sampled on the falling edge.
module tb_ram_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        boot_done, flash_req, flash_we, phi2, cpu_cs, cpu_we;
    logic        halt_req, diag_req, diag_we;
    logic [15:0] flash_addr, cpu_addr, diag_addr;
    logic [7:0]  flash_wdata, cpu_wdata, diag_wdata;

    logic        flash_ack, halt, diag_ack, ram_cs, ram_we;
    logic [7:0]  cpu_rdata, diag_rdata, ram_wdata, ram_rdata;
    logic [15:0] ram_addr;

    logic        g4_flash_ack, g4_halt, g4_diag_ack, g4_ram_cs, g4_ram_we;
    logic [7:0]  g4_cpu_rdata, g4_diag_rdata, g4_ram_wdata;
    logic [15:0] g4_ram_addr;
    logic [7:0]  g4_ram_rdata = 8'hEE;

    logic [7:0]  mem [0:65535];
    logic [7:0]  exp_q [$];

    int checks = 0, failures = 0;
    int cs_cnt = 0, g4_cs_cnt = 0, fack_cnt = 0, dack_cnt = 0, halt_cnt = 0, we_bad = 0;

    always #5 clk = ~clk;

    ram_port_arbiter #(.ADDR_W(16), .DATA_W(8), .CPU_GUARD(2)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .boot_done_i(boot_done),
        .flash_req_i(flash_req), .flash_addr_i(flash_addr), .flash_wdata_i(flash_wdata),
        .flash_we_i(flash_we), .flash_ack_o(flash_ack),
        .phi2_i(phi2), .cpu_cs_i(cpu_cs), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr),
        .cpu_wdata_i(cpu_wdata), .cpu_rdata_o(cpu_rdata),
        .halt_req_i(halt_req), .halt_o(halt),
        .diag_req_i(diag_req), .diag_addr_i(diag_addr), .diag_wdata_i(diag_wdata),
        .diag_we_i(diag_we), .diag_ack_o(diag_ack), .diag_rdata_o(diag_rdata),
        .ram_addr_o(ram_addr), .ram_wdata_o(ram_wdata), .ram_cs_o(ram_cs),
        .ram_we_o(ram_we), .ram_rdata_i(ram_rdata)
    );

    ram_port_arbiter #(.ADDR_W(16), .DATA_W(8), .CPU_GUARD(4)) u_g4 (
        .clk_i(clk), .rst_ni(rst_n), .boot_done_i(boot_done),
        .flash_req_i(flash_req), .flash_addr_i(flash_addr), .flash_wdata_i(flash_wdata),
        .flash_we_i(flash_we), .flash_ack_o(g4_flash_ack),
        .phi2_i(phi2), .cpu_cs_i(cpu_cs), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr),
        .cpu_wdata_i(cpu_wdata), .cpu_rdata_o(g4_cpu_rdata),
        .halt_req_i(halt_req), .halt_o(g4_halt),
        .diag_req_i(diag_req), .diag_addr_i(diag_addr), .diag_wdata_i(diag_wdata),
        .diag_we_i(diag_we), .diag_ack_o(g4_diag_ack), .diag_rdata_o(g4_diag_rdata),
        .ram_addr_o(g4_ram_addr), .ram_wdata_o(g4_ram_wdata), .ram_cs_o(g4_ram_cs),
        .ram_we_o(g4_ram_we), .ram_rdata_i(g4_ram_rdata)
    );

    // SRAM: read data appears one clk after ram_cs
    always @(posedge clk) begin
        if (ram_cs) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata     <= mem[ram_addr];
        end
    end

    always @(negedge clk) begin
        if (ram_cs)            cs_cnt++;
        if (g4_ram_cs)         g4_cs_cnt++;
        if (flash_ack)         fack_cnt++;
        if (diag_ack)          dack_cnt++;
        if (halt)              halt_cnt++;
        if (ram_we && !ram_cs) we_bad++;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Wait for an ack (bounded), returning ticks taken; 99 if it never came.
    task automatic wait_ack(input logic is_diag, output int n);
        n = 0;
        do begin
            tick(1);
            n++;
        end while (!(is_diag ? diag_ack : flash_ack) && n < 10);
        if (n >= 10) n = 99;
    endtask

    task automatic flash_access(input logic [15:0] a, input logic [7:0] d, input string tag);
        int n;
        flash_addr = a; flash_wdata = d; flash_we = 1'b1; flash_req = 1'b1;
        wait_ack(1'b0, n);
        chk(tag, n, 3);
        flash_req = 1'b0;
        tick(1);
    endtask

    task automatic diag_access(input logic [15:0] a, input logic [7:0] d, input logic we,
                               input string tag);
        int n;
        diag_addr = a; diag_wdata = d; diag_we = we; diag_req = 1'b1;
        wait_ack(1'b1, n);
        chk({tag, "_lat"}, n, 3);
        if (!we) chk({tag, "_data"}, diag_rdata, exp_q.pop_front());
        diag_req = 1'b0;
        tick(1);
    endtask

    // One phi2-high phase of 10 clk; a read result is due 7 clk after the rise.
    task automatic cpu_cycle(input logic [15:0] a, input logic [7:0] d, input logic we,
                             input string tag);
        int c0;
        c0 = cs_cnt;
        cpu_addr = a; cpu_wdata = d; cpu_we = we; cpu_cs = 1'b1; phi2 = 1'b1;
        tick(7);
        if (!we) chk({tag, "_rdata"}, cpu_rdata, exp_q.pop_front());
        tick(3);
        phi2 = 1'b0; cpu_cs = 1'b0;
        tick(4);
        chk({tag, "_slots"}, cs_cnt - c0, 1);
    endtask

    initial begin
        int c0, c1, n;
        logic [7:0] diag_exp;
        rst_n = 1'b0; boot_done = 0; flash_req = 0; flash_we = 0; phi2 = 0;
        cpu_cs = 0; cpu_we = 0; halt_req = 0; diag_req = 0; diag_we = 0;
        flash_addr = '0; cpu_addr = '0; diag_addr = '0;
        flash_wdata = '0; cpu_wdata = '0; diag_wdata = '0;
        tick(3);
        rst_n = 1'b1;
        tick(1);
        chk("rst_halt", halt, 1'b0);
        chk("rst_cs", ram_cs, 1'b0);
        chk("rst_cpu_rdata", cpu_rdata, 8'h00);

        // Boot load, then boot_done pulses (sticky)
        flash_access(16'h1234, 8'hA5, "flash_lat0");
        flash_access(16'h8000, 8'h77, "flash_lat1");
        boot_done = 1'b1; tick(2); boot_done = 1'b0; tick(2);

        exp_q.push_back(8'hA5);
        cpu_cycle(16'h1234, 8'h00, 1'b0, "boot_read");
        chk("g4_long_read", g4_cpu_rdata, 8'hEE);

        // Short phi2 phase: guard of 4 never expires
        c0 = g4_cs_cnt;
        cpu_addr = 16'h1234; cpu_we = 1'b0; cpu_cs = 1'b1; phi2 = 1'b1;
        tick(3);
        phi2 = 1'b0;
        tick(6);
        cpu_cs = 1'b0;
        chk("short_phi2_cs", g4_cs_cnt - c0, 0);
        chk("short_phi2_rdata", g4_cpu_rdata, 8'hEE);

        // Halt during a CPU write; diag_req rises together with halt_req
        c0 = cs_cnt; c1 = dack_cnt;
        cpu_addr = 16'h0200; cpu_wdata = 8'h5A; cpu_we = 1'b1; cpu_cs = 1'b1; phi2 = 1'b1;
        tick(3);
        halt_req = 1'b1;
        diag_addr = 16'h0200; diag_we = 1'b0; diag_req = 1'b1;
        tick(7);
        chk("halt_during_phi2", halt, 1'b0);
        phi2 = 1'b0; cpu_cs = 1'b0;
        tick(2);
        chk("halt_before_sync", halt, 1'b0);
        tick(1);
        chk("halt_rise", halt, 1'b1);
        chk("halt_write_slots", cs_cnt - c0, 1);
        chk("diag_held_off", dack_cnt - c1, 0);
        wait_ack(1'b1, n);
        chk("diag_after_halt_lat", n, 3);
        chk("diag_after_halt_data", diag_rdata, 8'h5A);
        diag_req = 1'b0;
        tick(1);

        exp_q.push_back(8'h5A);
        diag_access(16'h0200, 8'h00, 1'b0, "diag_rd200");

        // Diag write then readback
        diag_access(16'h8000, 8'h3C, 1'b1, "diag_wr8000");
        chk("diag_wr_keeps_rdata", diag_rdata, 8'h5A);
`ifdef RAM_ARB_DIAG_WRITE_EN
        diag_exp = 8'h3C;
`else
        diag_exp = 8'h77;
`endif
        exp_q.push_back(diag_exp);
        diag_access(16'h8000, 8'h00, 1'b0, "diag_rd8000");

        halt_req = 1'b0;
        tick(1);
        chk("halt_release", halt, 1'b0);

        // Gating: diag in RUN, flash after boot
        c0 = cs_cnt; c1 = dack_cnt;
        diag_addr = 16'h0000; diag_we = 1'b0; diag_req = 1'b1;
        tick(8);
        diag_req = 1'b0;
        #1;
        chk("diag_in_run_ack", dack_cnt - c1, 0);
        chk("diag_in_run_cs", cs_cnt - c0, 0);
        c0 = cs_cnt; c1 = fack_cnt;
        flash_addr = 16'h0200; flash_wdata = 8'hFF; flash_we = 1'b1; flash_req = 1'b1;
        tick(8);
        flash_req = 1'b0;
        #1;
        chk("flash_after_boot_ack", fack_cnt - c1, 0);
        chk("flash_after_boot_cs", cs_cnt - c0, 0);

        // halt_req withdrawn while pending
        tick(1);
        cpu_cs = 1'b0; phi2 = 1'b1;
        tick(3); halt_req = 1'b1;
        tick(3); halt_req = 1'b0;
        tick(4); phi2 = 1'b0;
        c0 = halt_cnt;
        tick(6);
        #1;
        chk("halt_withdrawn", halt_cnt - c0, 0);
        tick(1);
        exp_q.push_back(8'h5A);
        cpu_cycle(16'h0200, 8'h00, 1'b0, "after_withdraw");

        // Asynchronous reset in the middle of a CPU access
        c1 = fack_cnt + dack_cnt;
        cpu_addr = 16'h1234; cpu_we = 1'b0; cpu_cs = 1'b1; phi2 = 1'b1;
        tick(5);
        chk("cs_before_reset", ram_cs, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_cs", ram_cs, 1'b0);
        chk("arst_addr", ram_addr, 16'h0000);
        chk("arst_cpu_rdata", cpu_rdata, 8'h00);
        chk("arst_diag_rdata", diag_rdata, 8'h00);
        chk("arst_halt", halt, 1'b0);
        tick(3);
        phi2 = 1'b0; cpu_cs = 1'b0;
        chk("arst_no_ack", fack_cnt + dack_cnt - c1, 0);
        rst_n = 1'b1;
        tick(1);
        flash_access(16'h0010, 8'h42, "boot_after_reset");
        chk("we_only_with_cs", we_bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
